// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring
// divider sharing one 64-bit accumulator, one bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; operands latched and magnitudes formed on accept
// CALC  | 32 shift-add or restoring-divide iterations (cnt 0..31)
// FIX   | sign correction, output select, result write
// DONE  | done pulse for one cycle, then IDLE
module muldiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] result_q, result_d;

    logic        a_sgn, b_sgn, div_zero, div_ovf;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_res;

    always_comb begin
        a_sgn    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_mag    = (a_sgn && a[31]) ? (~a + 32'd1) : a;
        b_mag    = (b_sgn && b[31]) ? (~b + 32'd1) : b;
        div_zero = op[2] && (b == 32'd0);
        div_ovf  = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end

    // Accumulator holds {high partial product, remaining multiplier bits}
    // for multiply and {partial remainder, dividend/quotient bits} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        div_sh   = {acc_q[63:32], acc_q[31]};
        div_ge   = (div_sh >= {1'b0, opb_q});
        div_rem  = div_ge ? (div_sh[31:0] - opb_q) : div_sh[31:0];
        div_next = {div_rem, acc_q[30:0], div_ge};
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        case (op_q)
            3'b000:                  fix_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011:  fix_res = prod_fix[63:32];
            3'b100, 3'b101:          fix_res = quo_fix;
            default:                 fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d    = op;
                    neg_a_d = a_sgn && a[31];
                    neg_b_d = b_sgn && b[31];
                    acc_d   = {32'd0, a_mag};
                    opb_d   = b_mag;
                    cnt_d   = 5'd0;
                    if (div_zero) begin
                        result_d = op[1] ? a : 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
